// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the RV32I multicycle control path.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  localparam logic [1:0] A_RS1    = 2'd0;
  localparam logic [1:0] A_PC     = 2'd1;
  localparam logic [1:0] A_ZERO   = 2'd2;

  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_LOAD  = 2'd1;
  localparam logic [1:0] WB_PC4   = 2'd2;

  function automatic logic opcode_supported(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_OP, OPC_STORE, OPC_BRANCH,
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv_alu_op_gen.sv
// Maps decoder fields to an ALU operation and flags illegal R-type funct7.
module rv_alu_op_gen
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       instr_bit30,
  output logic [3:0] alu_op,
  output logic       illegal_r
);

  logic is_op;
  logic alt;

  assign is_op = (opcode == OPC_OP);
  // R-type takes the alternate encoding from funct7; OP-IMM only from raw bit 30
  assign alt   = is_op ? funct7[5] : instr_bit30;

  // Decode funct3 (plus alternate bit) into an ALU operation
  always_comb begin
    alu_op    = ALU_ADD;
    illegal_r = 1'b0;
    if (is_op) begin
      illegal_r = !((funct7 == 7'b0000000) ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
    end
    if (is_op || opcode == OPC_OP_IMM) begin
      case (funct3)
        3'b000:  alu_op = (is_op && funct7[5]) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_op = ALU_SLL;
        3'b010:  alu_op = ALU_SLT;
        3'b011:  alu_op = ALU_SLTU;
        3'b100:  alu_op = ALU_XOR;
        3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
        3'b110:  alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle control FSM for the RV32I core: sequencing, strobes, handshake, traps.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             instr_bit30,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [1:0]       a_sel,
  output logic             b_sel,
  output logic [3:0]       alu_op,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic             bus_err,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  state_t             state;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               illegal_q, bus_err_q;
  logic [CNT_W-1:0]   instret_q;

  logic [3:0] gen_op;
  logic       illegal_r;
  logic [1:0] a_x;
  logic       b_x;
  logic [3:0] alu_x;
  logic       is_load, is_store, timeout;

  logic       mem_req_c, mem_we_c, addr_sel_c, ir_we_c, pc_we_c, b_sel_c, rf_we_c;
  logic [1:0] pc_sel_c, a_sel_c, wb_sel_c;
  logic [3:0] alu_op_c;

  rv_alu_op_gen u_alu_op_gen (
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .instr_bit30 (instr_bit30),
    .alu_op      (gen_op),
    .illegal_r   (illegal_r)
  );

  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  // Request cycle with count already at MAX_WAIT: only mem_ready can save it
  assign timeout  = (wait_cnt == WAIT_W'(MAX_WAIT));

  // ALU operand/operation selects for the current instruction, held EXECUTE..WRITEBACK
  always_comb begin
    a_x   = A_RS1;
    b_x   = 1'b1;
    alu_x = ALU_ADD;
    case (opcode)
      OPC_OP:     begin b_x = 1'b0; alu_x = gen_op; end
      OPC_OP_IMM: alu_x = gen_op;
      OPC_LUI:    a_x = A_ZERO;
      OPC_AUIPC:  a_x = A_PC;
      OPC_BRANCH: b_x = 1'b0;
      default:    ;
    endcase
  end

  // Per-state datapath strobes; ir_we, pc_sel and MEM completion follow live inputs
  always_comb begin
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    addr_sel_c = 1'b0;
    ir_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    pc_sel_c   = PC_PLUS4;
    a_sel_c    = A_RS1;
    b_sel_c    = 1'b0;
    alu_op_c   = ALU_ADD;
    rf_we_c    = 1'b0;
    wb_sel_c   = WB_ALU;
    case (state)
      S_FETCH: begin
        mem_req_c = 1'b1;
        ir_we_c   = mem_ready;
      end
      S_EXECUTE: begin
        a_sel_c  = a_x;
        b_sel_c  = b_x;
        alu_op_c = alu_x;
        case (opcode)
          OPC_BRANCH: begin
            pc_we_c  = 1'b1;
            pc_sel_c = branch_taken ? PC_IMM : PC_PLUS4;
          end
          OPC_JAL: begin
            pc_we_c  = 1'b1;
            pc_sel_c = PC_IMM;
            rf_we_c  = 1'b1;
            wb_sel_c = WB_PC4;
          end
          OPC_JALR: begin
            pc_we_c  = 1'b1;
            pc_sel_c = PC_JALR;
            rf_we_c  = 1'b1;
            wb_sel_c = WB_PC4;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        a_sel_c    = a_x;
        b_sel_c    = b_x;
        alu_op_c   = alu_x;
        mem_req_c  = 1'b1;
        addr_sel_c = 1'b1;
        mem_we_c   = is_store;
        pc_we_c    = is_store && mem_ready;
      end
      S_WRITEBACK: begin
        a_sel_c  = a_x;
        b_sel_c  = b_x;
        alu_op_c = alu_x;
        rf_we_c  = 1'b1;
        wb_sel_c = is_load ? WB_LOAD : WB_ALU;
        pc_we_c  = 1'b1;
      end
      default: ;
    endcase
  end

  // State sequencing, wait counter, sticky trap flags and retirement counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      instret_q <= '0;
    end else begin
      if (pc_we_c) instret_q <= instret_q + CNT_W'(1);
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            state    <= S_DECODE;
            wait_cnt <= '0;
          end else if (timeout) begin
            state     <= S_TRAP;
            bus_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          if (!opcode_supported(opcode) || illegal_r) begin
            state     <= S_TRAP;
            illegal_q <= 1'b1;
          end else begin
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          wait_cnt <= '0;
          case (opcode)
            OPC_LOAD, OPC_STORE:          state <= S_MEM;
            OPC_BRANCH, OPC_JAL, OPC_JALR: state <= S_FETCH;
            default:                      state <= S_WRITEBACK;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            state    <= is_store ? S_FETCH : S_WRITEBACK;
            wait_cnt <= '0;
          end else if (timeout) begin
            state     <= S_TRAP;
            bus_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_WRITEBACK: begin
          state    <= S_FETCH;
          wait_cnt <= '0;
        end
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Outputs are blanked combinationally while rst is high so no strobe leaks in the reset cycle
  assign mem_req  = rst ? 1'b0 : mem_req_c;
  assign mem_we   = rst ? 1'b0 : mem_we_c;
  assign addr_sel = rst ? 1'b0 : addr_sel_c;
  assign ir_we    = rst ? 1'b0 : ir_we_c;
  assign pc_we    = rst ? 1'b0 : pc_we_c;
  assign pc_sel   = rst ? '0   : pc_sel_c;
  assign a_sel    = rst ? '0   : a_sel_c;
  assign b_sel    = rst ? 1'b0 : b_sel_c;
  assign alu_op   = rst ? '0   : alu_op_c;
  assign rf_we    = rst ? 1'b0 : rf_we_c;
  assign wb_sel   = rst ? '0   : wb_sel_c;
  assign illegal  = rst ? 1'b0 : illegal_q;
  assign bus_err  = rst ? 1'b0 : bus_err_q;
  assign state_o  = rst ? '0   : state;
  assign instret  = rst ? '0   : instret_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Self-checking bench for rv_multicycle_ctrl: directed cases plus random instruction stream.
module tb_rv_multicycle_ctrl;

  localparam int unsigned CW = 4;
  localparam int unsigned MW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    opcode = '0;
  logic [2:0]    funct3 = '0;
  logic [6:0]    funct7 = '0;
  logic          instr_bit30 = 1'b0;
  logic          branch_taken = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, addr_sel, ir_we, pc_we, b_sel, rf_we, illegal, bus_err;
  logic [1:0]    pc_sel, a_sel, wb_sel;
  logic [3:0]    alu_op;
  logic [2:0]    state_o;
  logic [CW-1:0] instret;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned exp_ret = 0;

  rv_multicycle_ctrl #(.CNT_W(CW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .instr_bit30(instr_bit30), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .a_sel(a_sel), .b_sel(b_sel), .alu_op(alu_op),
    .rf_we(rf_we), .wb_sel(wb_sel), .illegal(illegal), .bus_err(bus_err),
    .state_o(state_o), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ret_mod(input int unsigned n);
    return n % (32'd1 << CW);
  endfunction

  // Reference ALU operation from the RV32I instruction tables
  function automatic int unsigned ref_alu(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic b30);
    int unsigned tbl [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    if (op != 7'h33 && op != 7'h13) return 0;
    if (op == 7'h33 && f3 == 3'b000 && f7 == 7'h20) return 1;
    if (f3 == 3'b101 && ((op == 7'h33) ? (f7 == 7'h20) : b30)) return 7;
    return tbl[f3];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'($urandom);
    branch_taken = 1'($urandom);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_pc_we", pc_we, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_ir_we", ir_we, 0);
    chk("rst_state", state_o, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_instret", instret, 0);
    tick();
    rst = 1'b0;
    exp_ret = 0;
  endtask

  task automatic expect_trap(input logic il, input logic be);
    for (int unsigned i = 0; i < 10; i++) begin
      mem_ready = 1'($urandom);
      #1;
      chk("t_state", state_o, 5);
      chk("t_illegal", illegal, il);
      chk("t_bus_err", bus_err, be);
      chk("t_mem_req", mem_req, 0);
      chk("t_pc_we", pc_we, 0);
      chk("t_rf_we", rf_we, 0);
      chk("t_ir_we", ir_we, 0);
      chk("t_instret", instret, ret_mod(exp_ret));
      tick();
    end
    do_reset();
  endtask

  task automatic chk_alu(input string p, input int unsigned ea, input int unsigned eb,
                         input int unsigned eop);
    chk({p, "_a_sel"}, a_sel, ea);
    chk({p, "_b_sel"}, b_sel, eb);
    chk({p, "_alu_op"}, alu_op, eop);
  endtask

  // Drive one instruction word through the controller; fw/mw are not-ready cycles before mem_ready
  task automatic run_instr(input logic [31:0] ins, input int unsigned fw, input int unsigned mw,
                           input logic taken);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, is_r, is_i, legal;
    int unsigned ea, eb, eop;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    is_ld = (op == 7'h03);  is_st = (op == 7'h23);  is_br = (op == 7'h63);
    is_jal = (op == 7'h6F); is_jalr = (op == 7'h67); is_lui = (op == 7'h37);
    is_auipc = (op == 7'h17); is_r = (op == 7'h33); is_i = (op == 7'h13);
    if (is_lui || is_auipc || is_jal) f3 = 3'b000;
    if (!is_r) f7 = 7'b0;
    legal = is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc | is_r | is_i;
    if (is_r && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)))) legal = 1'b0;
    ea  = is_lui ? 2 : (is_auipc ? 1 : 0);
    eb  = is_r ? 0 : 1;
    eop = ref_alu(op, f3, f7, ins[30]);
    opcode = op; funct3 = f3; funct7 = f7; instr_bit30 = ins[30];
    #1;
    chk("start_state", state_o, 0);
    chk("start_instret", instret, ret_mod(exp_ret));
    chk("start_illegal", illegal, 0);
    chk("start_bus_err", bus_err, 0);

    for (int unsigned i = 0; i <= MW && i <= fw; i++) begin
      mem_ready = (i == fw);
      #1;
      chk("f_state", state_o, 0);
      chk("f_mem_req", mem_req, 1);
      chk("f_addr_sel", addr_sel, 0);
      chk("f_mem_we", mem_we, 0);
      chk("f_ir_we", ir_we, 32'(i == fw));
      chk("f_pc_we", pc_we, 0);
      tick();
    end
    if (fw > MW) begin expect_trap(1'b0, 1'b1); return; end

    mem_ready = 1'($urandom);
    #1;
    chk("d_state", state_o, 1);
    chk("d_mem_req", mem_req, 0);
    chk("d_ir_we", ir_we, 0);
    chk("d_pc_we", pc_we, 0);
    chk("d_rf_we", rf_we, 0);
    tick();
    if (!legal) begin expect_trap(1'b1, 1'b0); return; end

    branch_taken = taken;
    mem_ready = 1'($urandom);
    #1;
    chk("x_state", state_o, 2);
    chk("x_mem_req", mem_req, 0);
    if (is_br || is_jal || is_jalr) begin
      chk("x_pc_we", pc_we, 1);
      chk("x_pc_sel", pc_sel, is_jalr ? 2 : ((is_jal || taken) ? 1 : 0));
      chk("x_rf_we", rf_we, 32'(!is_br));
      if (!is_br) chk("x_wb_sel", wb_sel, 2);
      if (is_jalr) chk_alu("x", 0, 1, 0);
      tick();
      exp_ret++;
      return;
    end
    chk("x_pc_we", pc_we, 0);
    chk("x_rf_we", rf_we, 0);
    chk_alu("x", ea, eb, eop);
    tick();

    if (is_ld || is_st) begin
      for (int unsigned i = 0; i <= MW && i <= mw; i++) begin
        mem_ready = (i == mw);
        #1;
        chk("m_state", state_o, 3);
        chk("m_mem_req", mem_req, 1);
        chk("m_addr_sel", addr_sel, 1);
        chk("m_mem_we", mem_we, 32'(is_st));
        chk("m_pc_we", pc_we, 32'(is_st && i == mw));
        chk("m_pc_sel", pc_sel, 0);
        chk("m_rf_we", rf_we, 0);
        chk_alu("m", 0, 1, 0);
        tick();
      end
      if (mw > MW) begin expect_trap(1'b0, 1'b1); return; end
      if (is_st) begin exp_ret++; return; end
    end

    mem_ready = 1'($urandom);
    #1;
    chk("w_state", state_o, 4);
    chk("w_rf_we", rf_we, 1);
    chk("w_wb_sel", wb_sel, is_ld ? 1 : 0);
    chk("w_pc_we", pc_we, 1);
    chk("w_pc_sel", pc_sel, 0);
    chk("w_mem_req", mem_req, 0);
    chk_alu("w", ea, eb, eop);
    tick();
    exp_ret++;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h13};
    logic [31:0] w;
    int unsigned sel;
    w = $urandom;
    sel = $urandom_range(0, 11);
    if (sel < 10) w[6:0] = ops[sel];
    if (w[6:0] == 7'h33 && $urandom_range(0, 3) != 0)
      w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return w;
  endfunction

  function automatic int unsigned rand_wait();
    return ($urandom_range(0, 19) == 0) ? MW + 1 : $urandom_range(0, MW);
  endfunction

  initial begin
    do_reset();
    run_instr(32'h00500093, 0, 0, 1'b0);   // ADDI x1,x0,5
    run_instr(32'h0000A103, 0, 3, 1'b0);   // LW, three not-ready MEM cycles
    run_instr(32'h00208463, 0, 0, 1'b1);   // BEQ taken
    run_instr(32'h00208463, 0, 0, 1'b0);   // BEQ not taken
    run_instr(32'h4010D093, 0, 0, 1'b0);   // SRAI
    run_instr(32'h0010D093, 0, 0, 1'b0);   // SRLI
    run_instr(32'h40208033, 0, 0, 1'b0);   // SUB
    run_instr(32'h0020F1B3, 1, 0, 1'b0);   // AND
    run_instr(32'h0020A023, 0, 2, 1'b0);   // SW
    run_instr(32'h008000EF, 0, 0, 1'b0);   // JAL
    run_instr(32'h000100E7, 0, 0, 1'b0);   // JALR
    run_instr(32'h000010B7, 0, 0, 1'b0);   // LUI
    run_instr(32'h00001097, 0, 0, 1'b0);   // AUIPC
    run_instr(32'h0000A103, MW, MW, 1'b0); // ready on the last permitted cycle
    run_instr(32'h0000007F, 0, 0, 1'b0);   // unsupported opcode
    run_instr(32'h02208033, 0, 0, 1'b0);   // funct7=0000001 R-type
    run_instr(32'h40209033, 0, 0, 1'b0);   // funct7=0100000 with funct3=001
    run_instr(32'h00500093, MW + 1, 0, 1'b0); // fetch timeout
    run_instr(32'h0000A103, 0, MW + 1, 1'b0); // load timeout

    // Reset in the middle of a load's MEM phase
    do_reset();
    opcode = 7'h03; funct3 = 3'b010; funct7 = 7'h00; instr_bit30 = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    #1;
    chk("mm_state", state_o, 3);
    chk("mm_mem_req", mem_req, 1);
    rst = 1'b1;
    #1;
    chk("mm_rst_mem_req", mem_req, 0);
    chk("mm_rst_pc_we", pc_we, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("mm_after_state", state_o, 0);
    chk("mm_after_instret", instret, 0);
    chk("mm_after_mem_req", mem_req, 1);

    repeat (80) run_instr(rand_instr(), rand_wait(), rand_wait(), 1'($urandom));

    #1;
    chk("final_instret", instret, ret_mod(exp_ret));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Multicycle control FSM for the RV32I core.
- Sequences fetch, decode, execute, memory and writeback using the field outputs of the instruction decoder (opcode, funct3, funct7) and the branch comparator.
- Drives the memory request handshake and every datapath strobe and mux select.
- Counts retired instructions and traps on illegal instructions or memory timeout.

Parameters:
- CNT_W, 32, width of retired-instruction counter instret.
- MAX_WAIT, 255, cycles a memory request may wait for mem_ready before bus error.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- opcode  in  7  decoder opcode.
- funct3  in  3  decoder funct3 (zero for U/J).
- funct7  in  7  decoder funct7 (non-zero only for R-type).
- instr_bit30  in  1  raw instruction bit 30, selects SRAI vs SRLI (decoder zeroes funct7 for I-type).
- branch_taken  in  1  comparator result for current funct3, valid in EXECUTE.
- mem_ready  in  1  memory completes request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  store request.
- addr_sel  out  1  memory address: 0=PC, 1=ALU result.
- ir_we  out  1  instruction register load.
- pc_we  out  1  PC load (marks retirement).
- pc_sel  out  2  0=PC+4, 1=PC+imm, 2=(rs1+imm)&~1.
- a_sel  out  2  ALU A: 0=rs1, 1=PC, 2=zero.
- b_sel  out  1  ALU B: 0=rs2, 1=imm.
- alu_op  out  4  ALU operation, package encoding.
- rf_we  out  1  register file write.
- wb_sel  out  2  writeback data: 0=ALU, 1=load data, 2=PC+4.
- illegal  out  1  sticky illegal-instruction flag.
- bus_err  out  1  sticky memory-timeout flag.
- state_o  out  3  current state (debug).
- instret  out  CNT_W  retired-instruction count.

Behaviour:
Reset:
- While rst is high, every output is forced to 0, including mem_req.
- On the next edge: state=FETCH, instret=0, illegal=0, bus_err=0, wait counter=0.
- Reset mid-operation abandons the instruction. No strobe is asserted in the reset cycle.

States (encoding 0-5): FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
- Strobes not listed for a state are 0. alu_op defaults to ADD.

FETCH:
- mem_req=1, addr_sel=0.
- On a cycle with mem_ready=1: ir_we=1, next state DECODE. Otherwise stay.

DECODE:
- Exactly one cycle. The decoder immediate is updated on negedge, so imm is valid from EXECUTE.
- Unsupported opcode, or an illegal R-type funct7 -> TRAP. Legal R-type funct7 is 0000000, or 0100000 only with funct3 000/101.
- Otherwise -> EXECUTE.

EXECUTE, by instruction class:
- OP (R-type): a=rs1, b=rs2; alu_op from {funct7[5], funct3}. Next WRITEBACK.
- OP-IMM: a=rs1, b=imm; alu_op from funct3. SUB is never selected. SRA only when funct3=101 and instr_bit30=1. Next WRITEBACK.
- LUI: a=zero, b=imm. AUIPC: a=PC, b=imm. Both next WRITEBACK.
- LOAD/STORE: a=rs1, b=imm, ADD. Next MEM.
- BRANCH: pc_we=1; pc_sel=1 if branch_taken, else 0. No rf_we. Next FETCH.
- JAL: pc_we=1, pc_sel=1, rf_we=1, wb_sel=2, same edge. Next FETCH.
- JALR: a=rs1, b=imm; pc_we=1, pc_sel=2, rf_we=1, wb_sel=2. Next FETCH.

MEM:
- a/b/alu_op held from EXECUTE; mem_req=1, addr_sel=1, mem_we=1 for stores.
- On mem_ready: a store sets pc_we=1, pc_sel=0 and goes to FETCH; a load goes to WRITEBACK.

WRITEBACK:
- rf_we=1; wb_sel=1 for loads, else 0. ALU selects held.
- pc_we=1, pc_sel=0. Next FETCH.

TRAP:
- All strobes 0. illegal or bus_err remains 1.
- Exits only via rst.

Handshake and timeout:
- mem_req, mem_we and addr_sel stay stable until a cycle with mem_ready=1.
- The transfer completes at the edge where mem_req=1 and mem_ready=1. mem_ready while mem_req=0 is ignored.
- The wait counter clears on entering FETCH/MEM and increments on each waiting cycle.
- If it reaches MAX_WAIT with mem_ready still 0 -> TRAP with bus_err=1. If mem_ready arrives on the cycle the count hits MAX_WAIT, the request completes.

instret:
- +1 on every edge with pc_we=1; wraps modulo 2^CNT_W.

Latency (mem_ready immediate):
- ALU/LUI/AUIPC: 4 cycles.
- Branch/JAL/JALR: 3 cycles.
- Load: 5 cycles. Store: 4 cycles.

Decomposition:
- Package rv_ctrl_pkg holds:
  - the state enum;
  - opcode localparams (LOAD 0000011, OP_IMM 0010011, OP 0110011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111);
  - alu_op enum ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9;
  - pc_sel, a_sel and wb_sel encodings.
- One sub-module, rv_alu_op_gen: combinational mapping of {opcode, funct3, funct7, instr_bit30} to alu_op and illegal-R detect.

Test Plan:
- ADDI x1,x0,5 (0x00500093), mem_ready always 1 -> states 0,1,2,4. In EXECUTE b_sel=1, alu_op=0. In WRITEBACK rf_we=1, wb_sel=0, pc_we=1. instret 0->1 in 4 cycles.
- LW (0x0000A103), mem_ready held 0 for 3 MEM cycles -> mem_req=1, addr_sel=1, mem_we=0 for 4 cycles, then WRITEBACK with wb_sel=1; 8 cycles total.
- BEQ (0x00208463) with branch_taken=1 then 0 -> pc_sel=1 vs 0, rf_we=0, 3 cycles each, instret +2.
- SRAI (0x4010D093, instr_bit30=1) -> alu_op=7. SRLI (0x0010D093, instr_bit30=0) -> alu_op=6. SUB (0x40208033) -> alu_op=1.
- Opcode 0x7F -> TRAP after DECODE, illegal=1 and sticky, mem_req=0 for 10 further cycles; rst pulse clears the flag and fetch restarts.
- MAX_WAIT=4, mem_ready=0 in FETCH -> bus_err=1 and TRAP after 4 wait cycles. Separately, rst for 1 cycle mid-MEM -> mem_req=0 that cycle, FETCH next, instret unchanged.
